// File: rtl/greg_mp.sv
// Multi-ported register file: two write ports, three combinational read ports,
// optional hardwired zero entry, optional write-to-read bypass and a sequential clear engine.
module greg_mp #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wea,
  input  logic [AW-1:0] wa_num,
  input  logic [DW-1:0] wa_data,
  input  logic          web,
  input  logic [AW-1:0] wb_num,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] read1,
  input  logic [AW-1:0] read2,
  input  logic [AW-1:0] read3,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [DW-1:0] data3,
  output logic          busy,
  output logic          done
);

  localparam int unsigned DEPTH = 1 << AW;
  // One past the last index; reachable only because the counter has a spare bit.
  localparam logic [AW:0] CntEnd = (AW + 1)'(DEPTH);

  typedef enum logic {StIdle, StClear} state_e;

  state_e        state_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_nxt;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] mem_q [DEPTH] = '{default: '0};

  logic          wr_a;
  logic          wr_b;
  logic          wr_ok;
  logic [AW-1:0] raddr [3];
  logic [DW-1:0] rdata [3];

  assign cnt_nxt = cnt_q + 1'b1;

  // Writes land only in IDLE and only when neither reset nor a clear request claims the cycle.
  assign wr_ok = (state_q == StIdle) && !clr && !rst;
  assign wr_a  = wea && wr_ok && !(ZERO_REG && (wa_num == '0));
  assign wr_b  = web && wr_ok && !(ZERO_REG && (wb_num == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          cnt_q <= cnt_nxt;
          if (cnt_nxt == CntEnd) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Port B is applied last so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (state_q == StClear) begin
      mem_q[cnt_q[AW-1:0]] <= '0;
    end else begin
      if (wr_a) mem_q[wa_num] <= wa_data;
      if (wr_b) mem_q[wb_num] <= wb_data;
    end
  end

  assign raddr[0] = read1;
  assign raddr[1] = read2;
  assign raddr[2] = read3;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    always_comb begin
      rdata[p] = mem_q[raddr[p]];
      if (ZERO_REG && (raddr[p] == '0)) begin
        rdata[p] = '0;
      end else if (BYPASS) begin
        if (wr_b && (wb_num == raddr[p])) begin
          rdata[p] = wb_data;
        end else if (wr_a && (wa_num == raddr[p])) begin
          rdata[p] = wa_data;
        end
      end
    end
  end

  assign data1 = rdata[0];
  assign data2 = rdata[1];
  assign data3 = rdata[2];
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_greg_mp.sv
// Scoreboard bench for greg_mp: directed stimulus queues expectations, a negedge monitor checks.
module tb_greg_mp;

  localparam int SD1 = 0, SD2 = 1, SD3 = 2, SD2NB = 3, SBUSY = 4, SDONE = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clr, wea, web;
  logic [4:0]  wa_num, wb_num, read1, read2, read3;
  logic [31:0] wa_data, wb_data;
  logic [31:0] data1, data2, data3;
  logic        busy, done;
  logic [31:0] nb_data1, nb_data2, nb_data3;
  logic        nb_busy, nb_done;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  greg_mp dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wea(wea), .wa_num(wa_num), .wa_data(wa_data),
    .web(web), .wb_num(wb_num), .wb_data(wb_data),
    .read1(read1), .read2(read2), .read3(read3),
    .data1(data1), .data2(data2), .data3(data3),
    .busy(busy), .done(done)
  );

  greg_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .clr(clr),
    .wea(wea), .wa_num(wa_num), .wa_data(wa_data),
    .web(web), .wb_num(wb_num), .wb_data(wb_data),
    .read1(read1), .read2(read2), .read3(read3),
    .data1(nb_data1), .data2(nb_data2), .data3(nb_data3),
    .busy(nb_busy), .done(nb_done)
  );

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      SD1:     return data1;
      SD2:     return data2;
      SD3:     return data3;
      SD2NB:   return nb_data2;
      SBUSY:   return {31'd0, busy};
      default: return {31'd0, done};
    endcase
  endfunction

  task automatic expect_val(input string nm, input int s, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.sig  = s;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 32; i++) begin
      wea     = 1'b1;
      wa_num  = 5'(i);
      wa_data = base + 32'(i);
      tick();
    end
    wea = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = sig_val(e.sig);
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; wea = 1'b0; web = 1'b0;
    wa_num = '0; wb_num = '0; wa_data = '0; wb_data = '0;
    read1 = '0; read2 = '0; read3 = '0;
    tick();
    rst = 1'b0;

    // Reset state
    read1 = 5'd4;
    expect_val("reset busy", SBUSY, 0);
    expect_val("reset done", SDONE, 0);
    expect_val("reset entry4", SD1, 0);
    tick();

    // Dual write to one address: port B wins, also on the bypass path
    wea = 1'b1; wa_num = 5'd3; wa_data = 32'h11;
    web = 1'b1; wb_num = 5'd3; wb_data = 32'h22;
    read1 = 5'd3;
    expect_val("dual write bypass", SD1, 32'h22);
    tick();
    wea = 1'b0; web = 1'b0;
    expect_val("dual write stored", SD1, 32'h22);
    tick();

    // Bypass vs. no bypass
    wea = 1'b1; wa_num = 5'd5; wa_data = 32'hA;
    tick();
    wa_data = 32'hB; read2 = 5'd5;
    expect_val("bypass same cycle", SD2, 32'hB);
    expect_val("nobypass same cycle", SD2NB, 32'hA);
    tick();
    wea = 1'b0;
    expect_val("bypass after edge", SD2, 32'hB);
    expect_val("nobypass after edge", SD2NB, 32'hB);
    tick();

    // Zero register
    web = 1'b1; wb_num = 5'd0; wb_data = 32'hFFFF_FFFF; read3 = 5'd0;
    expect_val("zero reg same cycle", SD3, 0);
    tick();
    web = 1'b0;
    expect_val("zero reg after edge", SD3, 0);
    tick();

    fill(32'h100);
    read1 = 5'd7; read2 = 5'd0; read3 = 5'd31;
    expect_val("fill entry7", SD1, 32'h107);
    expect_val("fill entry0", SD2, 0);
    expect_val("fill entry31", SD3, 32'h11F);
    tick();

    // Clear accepted together with a write to entry 7
    clr = 1'b1; wea = 1'b1; wa_num = 5'd7; wa_data = 32'h5;
    expect_val("clr accept busy", SBUSY, 0);
    tick();
    clr = 1'b0; wea = 1'b0;
    for (int k = 0; k < 32; k++) begin
      read1 = (k > 0) ? 5'(k - 1) : 5'd0;
      read2 = 5'(k);
      read3 = 5'd20;
      if (k == 5) begin
        wea = 1'b1; wa_num = 5'd20; wa_data = 32'hDEAD;
        web = 1'b1; wb_num = 5'd21; wb_data = 32'hBEEF;
        clr = 1'b1;
      end else begin
        wea = 1'b0; web = 1'b0; clr = 1'b0;
      end
      expect_val($sformatf("clear k=%0d busy", k), SBUSY, 1);
      expect_val($sformatf("clear k=%0d done", k), SDONE, 0);
      if (k > 0) expect_val($sformatf("clear k=%0d cleared", k), SD1, 0);
      expect_val($sformatf("clear k=%0d pending", k), SD2, (k == 0) ? 32'h0 : 32'h100 + 32'(k));
      expect_val($sformatf("clear k=%0d entry20", k), SD3, (k <= 20) ? 32'h114 : 32'h0);
      tick();
    end
    wea = 1'b0; web = 1'b0;

    // Done cycle, with a new clear requested in it
    read1 = 5'd7; read2 = 5'd21; read3 = 5'd20;
    expect_val("done pulse", SDONE, 1);
    expect_val("done busy", SBUSY, 0);
    expect_val("entry7 after clear", SD1, 0);
    expect_val("entry21 after clear", SD2, 0);
    expect_val("entry20 after clear", SD3, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 32; k++) begin
      expect_val($sformatf("restart k=%0d busy", k), SBUSY, 1);
      expect_val($sformatf("restart k=%0d done", k), SDONE, 0);
      tick();
    end
    expect_val("restart done pulse", SDONE, 1);
    expect_val("restart done busy", SBUSY, 0);
    tick();
    expect_val("done single cycle", SDONE, 0);
    tick();

    // Reset at clear step 10
    fill(32'h200);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_val($sformatf("rclear k=%0d busy", k), SBUSY, 1);
      tick();
    end
    rst = 1'b1; read1 = 5'd15; read2 = 5'd9;
    expect_val("pre-reset entry15", SD1, 32'h20F);
    expect_val("pre-reset entry9", SD2, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read1 = 5'(i);
      expect_val($sformatf("post-reset entry%0d", i), SD1, 0);
      expect_val($sformatf("post-reset busy i=%0d", i), SBUSY, 0);
      expect_val($sformatf("post-reset done i=%0d", i), SDONE, 0);
      tick();
    end

    tick();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/greg_mp.md
GREG_MP -- requirements
Module: greg_mp

Interface
REQ-001 Parameter DW, default 32: data width of every register entry, in bits.
REQ-002 Parameter AW, default 5: address width; the file holds DEPTH = 2^AW entries.
REQ-003 Parameter ZERO_REG, default 1: when 1, entry 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to the read ports.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 clr  in  1  request for a sequential clear of all entries.
REQ-008 wea  in  1  write enable, port A.
REQ-009 wa_num  in  AW  write address, port A.
REQ-010 wa_data  in  DW  write data, port A.
REQ-011 web  in  1  write enable, port B.
REQ-012 wb_num  in  AW  write address, port B.
REQ-013 wb_data  in  DW  write data, port B.
REQ-014 read1, read2, read3  in  AW each  read addresses.
REQ-015 data1, data2, data3  out  DW each  read data; combinational from the addresses.
REQ-016 busy  out  1  high while the clear sequence runs.
REQ-017 done  out  1  one-cycle pulse when a clear sequence completes.

Function
REQ-018 The block SHALL use a two-state FSM with states IDLE and CLEAR.
REQ-019 Write port A: in IDLE, wea=1 writes wa_data to entry wa_num at the rising clock edge.
REQ-020 Write port B: in IDLE, web=1 writes wb_data to entry wb_num at the rising clock edge.
REQ-021 Same-address conflict: when wea=web=1 and wa_num==wb_num, the entry SHALL take wb_data (port B wins).
REQ-022 With ZERO_REG=1, writes to entry 0 are discarded and reads of address 0 return 0, with no bypass.
REQ-023 With BYPASS=0, dataN SHALL be the stored value of entry readN.
REQ-024 With BYPASS=1 in IDLE, if readN matches an enabled write address in the same cycle, dataN SHALL be that write data (port B over port A); otherwise dataN is the stored value.
REQ-025 The write-to-read latency SHALL be 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
REQ-026 IDLE -> CLEAR: on clr=1, an internal counter loads 0 and busy rises in the next cycle.
REQ-027 Write drop on clear: any write presented in the cycle clr is accepted SHALL be discarded (clear wins).
REQ-028 In CLEAR, each cycle SHALL zero the entry at the counter and increment the counter by 1.
REQ-029 Clear duration: busy SHALL stay high for exactly DEPTH cycles.
REQ-030 CLEAR -> IDLE: after zeroing entry DEPTH-1, the FSM returns to IDLE and done pulses high for exactly the first IDLE cycle.
REQ-031 In CLEAR, wea, web and clr SHALL be ignored, and there is no bypass.
REQ-032 Reads during CLEAR SHALL return the current stored contents: zero for entries already cleared, old values for the rest.
REQ-033 The counter is AW+1 bits wide so that termination is detected without wrap-around, including the case AW=1.
REQ-034 clr that arrives in the same cycle done is high SHALL start a new clear sequence.

Reset
REQ-035 rst=1 at a clock edge SHALL zero every entry in that cycle, force IDLE, clear the counter, drive busy=0 and done=0, and drop any write in that cycle.
REQ-036 rst SHALL take priority over clr, writes and an in-progress CLEAR; a clear interrupted by reset is not resumed.
REQ-037 All entries SHALL also initialise to zero at time 0 for simulation.

Verification
REQ-038 Dual write: wea, wa_num=3, wa_data=0x11 and web, wb_num=3, wb_data=0x22 in one cycle -> next cycle read1=3 gives 0x22.
REQ-039 Bypass: BYPASS=1, entry 5 holds 0xA, wea wa_num=5 wa_data=0xB, read2=5 -> data2=0xB in the same cycle; with BYPASS=0, data2=0xA.
REQ-040 Zero register: ZERO_REG=1, web wb_num=0 wb_data=0xFFFFFFFF, read3=0 -> data3=0 in the same cycle and after the edge.
REQ-041 Clear: all entries nonzero, pulse clr -> busy high 32 cycles, reads of entry 0..k-1 return 0 at clear step k, done pulses once, a wea during busy is ignored.
REQ-042 Reset mid-clear: rst at clear step 10 -> next cycle all 32 entries read 0, busy=0, done=0, with no done pulse later.
REQ-043 Simultaneous events: clr with wea wa_num=7 wa_data=0x5 -> entry 7 reads 0 after the clear; clr in the done cycle -> busy restarts the next cycle.
